// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: packed-BCD hh:mm:ss countdown timer with load,
// start, pause/resume, a one-cycle expiry pulse and a sticky expired level.
// Optional feature macro: BCD_COUNTDOWN_AUTO_RELOAD_EN. When it is defined,
// expiry reloads the last legal load value and the timer keeps running.
module bcd_countdown_timer #(
    parameter logic [7:0] HH_MAX = 8'h99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // True when both nibbles of a packed BCD byte are decimal digits.
    function automatic logic bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9);
    endfunction

    // Two-digit BCD decrement; 00 wraps to the supplied value.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
        logic [7:0] r;
        if (v[3:0] != 4'h0) begin
            r = {v[7:4], v[3:0] - 4'h1};
        end else if (v[7:4] != 4'h0) begin
            r = {v[7:4] - 4'h1, 4'h9};
        end else begin
            r = wrap;
        end
        return r;
    endfunction

    state_t     state_r;
    logic [7:0] hh_r, mm_r, ss_r;
    logic       running_r, done_r, expired_r, load_err_r;
    logic [7:0] hh_dec_s, mm_dec_s, ss_dec_s;
    logic       load_ok_s, value_zero_s, value_one_s;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    logic [7:0] sh_hh_r, sh_mm_r, sh_ss_r;
    logic       shadow_zero_s;
`endif

    // Load validation, zero/one detection and the borrow-chained decrement.
    always_comb begin
        load_ok_s    = bcd_digits_ok(ld_hh) && bcd_digits_ok(ld_mm) && bcd_digits_ok(ld_ss) &&
                       (ld_mm <= 8'h59) && (ld_ss <= 8'h59) && (ld_hh <= HH_MAX);
        value_zero_s = (hh_r == 8'h00) && (mm_r == 8'h00) && (ss_r == 8'h00);
        value_one_s  = (hh_r == 8'h00) && (mm_r == 8'h00) && (ss_r == 8'h01);
        ss_dec_s     = bcd_dec(ss_r, 8'h59);
        if (ss_r == 8'h00) begin
            mm_dec_s = bcd_dec(mm_r, 8'h59);
        end else begin
            mm_dec_s = mm_r;
        end
        if ((ss_r == 8'h00) && (mm_r == 8'h00)) begin
            hh_dec_s = bcd_dec(hh_r, 8'h00);
        end else begin
            hh_dec_s = hh_r;
        end
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        shadow_zero_s = (sh_hh_r == 8'h00) && (sh_mm_r == 8'h00) && (sh_ss_r == 8'h00);
`endif
    end

    // Control FSM and registered outputs; priority load > pause > start > ena.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            hh_r       <= 8'h00;
            mm_r       <= 8'h00;
            ss_r       <= 8'h00;
            running_r  <= 1'b0;
            done_r     <= 1'b0;
            expired_r  <= 1'b0;
            load_err_r <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            sh_hh_r    <= 8'h00;
            sh_mm_r    <= 8'h00;
            sh_ss_r    <= 8'h00;
`endif
        end else begin
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
            if (load) begin
                if (load_ok_s) begin
                    hh_r      <= ld_hh;
                    mm_r      <= ld_mm;
                    ss_r      <= ld_ss;
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                    expired_r <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                    sh_hh_r   <= ld_hh;
                    sh_mm_r   <= ld_mm;
                    sh_ss_r   <= ld_ss;
`endif
                end else begin
                    load_err_r <= 1'b1;
                end
            end else if (pause) begin
                if (state_r == ST_RUN) begin
                    state_r   <= ST_PAUSE;
                    running_r <= 1'b0;
                end
            end else if (start) begin
                if (((state_r == ST_IDLE) || (state_r == ST_PAUSE)) && !value_zero_s) begin
                    state_r   <= ST_RUN;
                    running_r <= 1'b1;
                end
            end else if (ena && (state_r == ST_RUN)) begin
                if (value_one_s) begin
                    done_r <= 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                    if (!shadow_zero_s) begin
                        hh_r <= sh_hh_r;
                        mm_r <= sh_mm_r;
                        ss_r <= sh_ss_r;
                    end else begin
                        hh_r      <= 8'h00;
                        mm_r      <= 8'h00;
                        ss_r      <= 8'h00;
                        state_r   <= ST_DONE;
                        running_r <= 1'b0;
                        expired_r <= 1'b1;
                    end
`else
                    hh_r      <= 8'h00;
                    mm_r      <= 8'h00;
                    ss_r      <= 8'h00;
                    state_r   <= ST_DONE;
                    running_r <= 1'b0;
                    expired_r <= 1'b1;
`endif
                end else begin
                    hh_r <= hh_dec_s;
                    mm_r <= mm_dec_s;
                    ss_r <= ss_dec_s;
                end
            end
        end
    end

    assign hh       = hh_r;
    assign mm       = mm_r;
    assign ss       = ss_r;
    assign running  = running_r;
    assign done     = done_r;
    assign expired  = expired_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer.
module tb_bcd_countdown_timer;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ena = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [7:0] ld_hh = 8'h00, ld_mm = 8'h00, ld_ss = 8'h00;
    logic [7:0] hh, mm, ss;
    logic       running, done, expired, load_err;
    int         tests = 0;
    int         fails = 0;

    bcd_countdown_timer #(.HH_MAX(8'h99)) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
        .start(start), .pause(pause),
        .hh(hh), .mm(mm), .ss(ss), .running(running),
        .done(done), .expired(expired), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // One clock cycle with the given control inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic l, input logic p, input logic s, input logic e);
        load = l; pause = p; start = s; ena = e;
        @(posedge clk);
        #1;
        load = 1'b0; pause = 1'b0; start = 1'b0; ena = 1'b0;
    endtask

    task automatic set_ld(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        ld_hh = h; ld_mm = m; ld_ss = s;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({hh, mm, ss, running, done, expired, load_err} !== 28'h0) begin
            fails++; $display("FAIL reset_init got %h:%h:%h r%b d%b e%b le%b want zeros", hh, mm, ss, running, done, expired, load_err);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        set_ld(8'h05, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (running !== 1'b1 || hh !== 8'h05) begin
            fails++; $display("FAIL reset_prerun got hh=%h r%b want 05 r1", hh, running);
        end
        #3 reset_n = 1'b0;
        #1;
        tests++;
        if ({hh, mm, ss, running, done, expired, load_err} !== 28'h0) begin
            fails++; $display("FAIL reset_async got %h:%h:%h r%b d%b e%b want zeros", hh, mm, ss, running, done, expired);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        tests++;
        if (running !== 1'b0 || {hh, mm, ss} !== 24'h0) begin
            fails++; $display("FAIL reset_idle got r%b %h:%h:%h want r0 00:00:00", running, hh, mm, ss);
        end
    endtask

    task automatic test_borrow();
        int dcount;
        set_ld(8'h10, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({hh, mm, ss} !== 24'h095959) begin
            fails++; $display("FAIL borrow_hh got %h:%h:%h want 09:59:59", hh, mm, ss);
        end
        set_ld(8'h01, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({hh, mm, ss} !== 24'h005959) begin
            fails++; $display("FAIL borrow_chain got %h:%h:%h want 00:59:59", hh, mm, ss);
        end
        dcount = 0;
        for (int i = 0; i < 3598; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            if (done === 1'b1) dcount++;
        end
        tests++;
        if ({hh, mm, ss} !== 24'h000001 || dcount != 0) begin
            fails++; $display("FAIL borrow_near got %h:%h:%h done=%0d want 00:00:01 done=0", hh, mm, ss, dcount);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (done !== 1'b1 || {hh, mm, ss} !== (AUTO ? 24'h010000 : 24'h000000) ||
            expired !== !AUTO || running !== AUTO) begin
            fails++; $display("FAIL borrow_expire got %h:%h:%h d%b e%b r%b want auto=%0d", hh, mm, ss, done, expired, running, AUTO);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (done !== 1'b0 || expired !== !AUTO || {hh, mm, ss} !== (AUTO ? 24'h005959 : 24'h000000)) begin
            fails++; $display("FAIL borrow_after got %h:%h:%h d%b e%b", hh, mm, ss, done, expired);
        end
    endtask

    task automatic test_invalid();
        set_ld(8'h00, 8'h00, 8'h10);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if ({hh, mm, ss} !== 24'h000010 || expired !== 1'b0 || load_err !== 1'b0) begin
            fails++; $display("FAIL inv_legal got %h:%h:%h e%b le%b want 00:00:10 e0 le0", hh, mm, ss, expired, load_err);
        end
        set_ld(8'h00, 8'h60, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (load_err !== 1'b1 || {hh, mm, ss} !== 24'h000010) begin
            fails++; $display("FAIL inv_mm60 got le%b %h:%h:%h want le1 00:00:10", load_err, hh, mm, ss);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (load_err !== 1'b0) begin
            fails++; $display("FAIL inv_pulse got le%b want 0", load_err);
        end
        set_ld(8'h00, 8'h00, 8'h0A);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (load_err !== 1'b1 || {hh, mm, ss} !== 24'h000010) begin
            fails++; $display("FAIL inv_ss0A got le%b %h:%h:%h want le1 00:00:10", load_err, hh, mm, ss);
        end
        set_ld(8'hA0, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (load_err !== 1'b1 || {hh, mm, ss} !== 24'h000010) begin
            fails++; $display("FAIL inv_hhA0 got le%b %h:%h:%h want le1 00:00:10", load_err, hh, mm, ss);
        end
        set_ld(8'h99, 8'h59, 8'h59);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (load_err !== 1'b0 || {hh, mm, ss} !== 24'h995959) begin
            fails++; $display("FAIL inv_hh99 got le%b %h:%h:%h want le0 99:59:59", load_err, hh, mm, ss);
        end
    endtask

    task automatic test_pause_resume();
        int dcount;
        set_ld(8'h00, 8'h00, 8'h10);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({hh, mm, ss} !== 24'h000007 || running !== 1'b1) begin
            fails++; $display("FAIL pr_run3 got %h:%h:%h r%b want 00:00:07 r1", hh, mm, ss, running);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        tests++;
        if ({hh, mm, ss} !== 24'h000007 || running !== 1'b0) begin
            fails++; $display("FAIL pr_pause got %h:%h:%h r%b want 00:00:07 r0", hh, mm, ss, running);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({hh, mm, ss} !== 24'h000007) begin
            fails++; $display("FAIL pr_frozen got %h:%h:%h want 00:00:07", hh, mm, ss);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        tests++;
        if ({hh, mm, ss} !== 24'h000007 || running !== 1'b1) begin
            fails++; $display("FAIL pr_resume got %h:%h:%h r%b want 00:00:07 r1", hh, mm, ss, running);
        end
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            if (done === 1'b1) dcount++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (dcount != 0 || done !== 1'b1 || {hh, mm, ss} !== (AUTO ? 24'h000010 : 24'h000000)) begin
            fails++; $display("FAIL pr_done got early=%0d d%b %h:%h:%h want early=0 d1", dcount, done, hh, mm, ss);
        end
    endtask

    task automatic test_collisions();
        set_ld(8'h00, 8'h00, 8'h03);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        set_ld(8'h00, 8'h00, 8'h05);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({hh, mm, ss} !== 24'h000005 || running !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL col_load_ena got %h:%h:%h r%b d%b want 00:00:05 r0 d0", hh, mm, ss, running, done);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({hh, mm, ss} !== 24'h000005) begin
            fails++; $display("FAIL col_idle_hold got %h:%h:%h want 00:00:05", hh, mm, ss);
        end
        set_ld(8'h00, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (running !== 1'b0 || done !== 1'b0 || {hh, mm, ss} !== 24'h0) begin
            fails++; $display("FAIL col_start_zero got r%b d%b %h:%h:%h want r0 d0 00:00:00", running, done, hh, mm, ss);
        end
    endtask

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [23:0] exp_v [4];
        logic        exp_d [4];
        exp_v[0] = 24'h000001; exp_d[0] = 1'b0;
        exp_v[1] = 24'h000002; exp_d[1] = 1'b1;
        exp_v[2] = 24'h000001; exp_d[2] = 1'b0;
        exp_v[3] = 24'h000002; exp_d[3] = 1'b1;
        set_ld(8'h00, 8'h00, 8'h02);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            tests++;
            if ({hh, mm, ss} !== exp_v[i] || done !== exp_d[i] || running !== 1'b1 || expired !== 1'b0) begin
                fails++; $display("FAIL auto_tick%0d got %h:%h:%h d%b r%b e%b want %h d%b r1 e0",
                                  i, hh, mm, ss, done, running, expired, exp_v[i], exp_d[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_borrow();
        test_invalid();
        test_pause_resume();
        test_collisions();
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Packed-BCD hh:mm:ss countdown timer, the down-counting counterpart of the team's 12-hour BCD time-of-day counter. Software or a front-panel controller loads a duration, then starts, pauses and resumes it. The block decrements once per `ena` tick, the same 1 Hz enable that drives the time-of-day counter. It flags expiry with a one-cycle pulse and a sticky level.

## Interface
- `HH_MAX`, default `8'h99`: largest legal BCD hours value accepted on load.
- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: one-cycle tick, decrement enable (1 Hz typical).
- `load`  in  1: capture `ld_hh`/`ld_mm`/`ld_ss`.
- `ld_hh`  in  8: BCD hours to load.
- `ld_mm`  in  8: BCD minutes to load.
- `ld_ss`  in  8: BCD seconds to load.
- `start`  in  1: start or resume the countdown.
- `pause`  in  1: freeze the countdown.
- `hh`  out  8: current BCD hours.
- `mm`  out  8: current BCD minutes.
- `ss`  out  8: current BCD seconds.
- `running`  out  1: high in RUN.
- `done`  out  1: one-cycle expiry pulse.
- `expired`  out  1: sticky high in DONE.
- `load_err`  out  1: one-cycle pulse when a load is rejected.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE.
- **Reset (async, `reset_n`=0):** state IDLE; hh=mm=ss=8'h00; running=done=expired=load_err=0.
- **Per-cycle priority:** `load` > `pause` > `start` > `ena`.
- **Load validation:** a load is legal when all of the following hold:
  - every nibble ≤ 9;
  - mm ≤ 8'h59 and ss ≤ 8'h59;
  - hh ≤ HH_MAX.
- **Legal load:** accepted in any state.
  - hh/mm/ss and the reload shadow take the loaded values.
  - State goes to IDLE; `expired` clears.
- **Illegal load:** the value is discarded, state is unchanged, and `load_err` pulses.
- **`start`:**
  - IDLE or PAUSE with a nonzero value → RUN.
  - IDLE with 00:00:00 → ignored.
  - Ignored in RUN and DONE.
- **`pause`:** RUN → PAUSE. Ignored in every other state.
- **Decrement:** occurs only in RUN on `ena`.
  - ss low nibble 0 → 9 with a borrow into the high nibble.
  - ss 00 → 59 with a borrow into mm.
  - mm 00 → 59 with a borrow into hh.
  - hh decrements in BCD, e.g. 8'h10 → 8'h09.
  - All arithmetic is nibble-wise 4-bit. No out-of-range BCD value is ever produced.
- **Expiry:** on the `ena` tick where the value is 00:00:01:
  - value becomes 00:00:00 and state goes to DONE;
  - `done`=1 for that one cycle;
  - `expired`=1 until a legal load or reset.
- **DONE:** the count holds at zero and `ena` has no effect.

## Timing
- All outputs are registered. Updates are visible on the clock edge that samples the input.
- Latency from `load` to new hh/mm/ss, and from `ena` to the decremented value, is 1 cycle.
- `running` rises the edge after `start` and falls the edge after `pause`. The same cycle as expiry also drops `running`.
- **`pause` with `ena` in the same cycle:** the pause wins and no decrement occurs.
- **`start` with `ena` in the same cycle (from PAUSE or IDLE):** no decrement. Decrementing begins at the next `ena`.
- **`load` with `ena` in RUN:** the load wins and state goes to IDLE. The loaded value is not decremented.
- `ena` held high continuously decrements once per cycle; there is no edge detection.
- **Reset asserted mid-count:** outputs clear immediately, without waiting for `clk`. Release is synchronized by the integrator.

## Configuration
- **`BCD_COUNTDOWN_AUTO_RELOAD_EN` defined:** on expiry, `done` still pulses. In that same cycle, hh/mm/ss take the reload shadow and state stays RUN. `expired` stays 0.
  - Exception: a shadow of 00:00:00 cannot run. It enters DONE as normal.
- **Macro undefined:** the shadow register and reload logic are absent; expiry always enters DONE.

## Test plan
- **Reset:** assert reset_n=0 mid-RUN with hh=8'h05 → all outputs zero without a clock edge; state IDLE.
- **Borrow chain:** load 01:00:00, start, one `ena` → 00:59:59. Then 3599 more `ena` → 00:00:00, `done` pulses once, `expired`=1, `running`=0.
- **Invalid loads:**
  - ld_mm=8'h60 → `load_err` pulse, previous value retained.
  - ld_ss=8'h0A → rejected.
  - ld_hh=8'h99 with HH_MAX=8'h99 → accepted.
- **Pause/resume:** load 00:00:10, start, 3 `ena` → 00:00:07. Pause with `ena` in the same cycle → stays 00:00:07. Start → resumes; 7 `ena` → `done`.
- **Collisions:**
  - `load` of 00:00:05 together with `ena` in RUN at 00:00:02 → 00:00:05, IDLE, no `done`.
  - `start` on 00:00:00 → stays IDLE.
- **Auto-reload (macro defined):** load 00:00:02, start, 4 `ena` → `done` pulses after the 2nd and 4th ticks, value 00:00:02 after each, `running` stays 1.
